// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed from an internal ring-buffer FIFO.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow
);

    localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
    localparam int ADDR_W      = $clog2(FIFO_DEPTH);
    localparam int PTR_W       = ADDR_W + 1;
    localparam int CNT_W       = $clog2(STOP_BITS * CLK_PER_BIT);
    localparam int BIT_W       = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    if (CLK_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0] head;
    logic                 empty, full, push, pop;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, busy_q, ovf_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == '0));
    assign level    = wr_ptr_q - rd_ptr_q;

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (in_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Going idle keeps busy high only if a word is being written on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                parity_q <= (^head) ^ 1'(PARITY_ODD);
`endif
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_START;
                        cnt_q   <= BIT_LOAD;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= push;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        cnt_q   <= BIT_LOAD;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (bit_q != LAST_BIT) begin
                        cnt_q   <= BIT_LOAD;
                        bit_q   <= bit_q + BIT_W'(1);
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        state_q <= S_PARITY;
                        cnt_q   <= BIT_LOAD;
                        tx_q    <= parity_q;
`else
                        state_q <= S_STOP;
                        cnt_q   <= STOP_LOAD;
                        tx_q    <= 1'b1;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        state_q <= S_STOP;
                        cnt_q   <= STOP_LOAD;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (pop) begin
                        state_q <= S_START;
                        cnt_q   <= BIT_LOAD;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= push;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes tx and compares.
module tb_uart_tx_fifo;

    localparam int BIT_CYC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_CYC  = BIT_CYC * (1 + 8 + P + 1);
    localparam int FRAME2_CYC = BIT_CYC * (1 + 8 + P + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ovf_clr = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] level;

    logic [7:0] in_data2 = '0;
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic       ovf_clr2 = 1'b0;
    logic       tx2, busy2, overflow2;
    logic [2:0] level2;

    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         frames_seen = 0;
    logic [7:0] exp_q[$];
    int         frame_starts[$];

    uart_tx_fifo #(
        .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .level(level), .overflow(overflow)
    );

    uart_tx_fifo #(
        .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .ovf_clr(ovf_clr2), .tx(tx2), .busy(busy2), .level(level2), .overflow(overflow2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_frame);
        in_data  = b;
        in_valid = 1'b1;
        if (expect_frame) exp_q.push_back(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int n, input int budget);
        int c = 0;
        while (frames_seen < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, frames_seen, n);
    endtask

    initial begin : monitor
        logic [7:0] d, e;
        logic       ok, ab, par;
        int         sc;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                sc = cyc; ok = 1'b1; ab = 1'b0; d = '0; par = 1'b0;
                for (int s = 1; s < BIT_CYC; s++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ab = 1'b1;
                    if (tx !== 1'b0) ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int s = 0; s < BIT_CYC; s++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) ab = 1'b1;
                        if (s == 0) d[b] = tx;
                        else if (tx !== d[b]) ok = 1'b0;
                    end
                end
`ifdef UART_TX_PARITY_EN
                for (int s = 0; s < BIT_CYC; s++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ab = 1'b1;
                    if (s == 0) par = tx;
                    else if (tx !== par) ok = 1'b0;
                end
`endif
                for (int s = 0; s < BIT_CYC; s++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ab = 1'b1;
                    if (tx !== 1'b1) ok = 1'b0;
                end
                if (!ab) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", d, e);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", par, ^e);
`endif
                    end
                    check("frame_shape", ok, 1);
                    frame_starts.push_back(sc);
                    frames_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         len, bad, base, c;
        logic [15:0] slots;
        logic        par_s;

        // Reset state
        #23;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: single byte 0xA5
        push_byte(8'hA5, 1'b1);
        check("t1_level_after_e0", level, 1);
        @(posedge clk);
        #1;
        check("t1_tx_after_e1", tx, 0);
        check("t1_level_after_e1", level, 0);
        len = 0;
        while (busy === 1'b1 && len < 400) begin
            @(posedge clk);
            #1;
            len++;
        end
        check("t1_frame_len", len, FRAME_CYC);
        wait_frames("t1_frames", 1, 20);
        check("t1_idle_tx", tx, 1);
        check("t1_idle_busy", busy, 0);

        // Test 2: five consecutive pushes, fifth fills the FIFO
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i);
            exp_q.push_back(8'(i));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t2_level_full", level, 4);
        check("t2_in_ready_low", in_ready, 0);

        // Test 3: overflow while full; set wins over a simultaneous clear
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        check("t3_ovf_set", overflow, 1);
        check("t3_level_held", level, 4);
        @(posedge clk);
        #1;
        check("t3_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", overflow, 0);
        wait_frames("t2_frames", 6, 5 * FRAME_CYC + 50);
        for (int i = 2; i <= 5; i++) begin
            check("t2_no_gap", frame_starts[i] - frame_starts[i-1], FRAME_CYC);
        end

        // Test 4: 12-byte stream through the wrapping pointers
        repeat (3) @(posedge clk);
        #1;
        base = frames_seen;
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h12, 1'b1);
        for (int k = 3; k < 12; k++) begin
            wait_frames("t4_step", base + k - 2, FRAME_CYC + 50);
            check("t4_depth_ok", level <= 3, 1);
            push_byte(8'(8'h10 + k), 1'b1);
        end
        wait_frames("t4_frames", base + 12, 4 * FRAME_CYC);
        repeat (2) @(posedge clk);
        #1;
        check("t4_level_empty", level, 0);
        check("t4_busy_low", busy, 0);

        // Test 5: reset during data bit 3 of 0xFF with two bytes queued
        base = frames_seen;
        push_byte(8'hFF, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_data = 8'h66;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_level_queued", level, 2);
        repeat (42) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_level", level, 0);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_no_residual", bad, 0);
        check("t5_frames_unchanged", frames_seen, base);

        // Test 6: two stop bits (and parity when compiled in) on 0x07
        slots = '1;
        slots[0] = 1'b0;
        for (int i = 0; i < 8; i++) slots[1+i] = (i < 3);
        if (P == 1) slots[9] = 1'b1;
        in_data2  = 8'h07;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        c = 0;
        while (tx2 !== 1'b0 && c < 5) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("t6_start_seen", tx2, 0);
        len = 0;
        bad = 0;
        par_s = 1'b0;
        while (busy2 === 1'b1 && len < 400) begin
            if (len / BIT_CYC < 16) begin
                if (tx2 !== slots[len / BIT_CYC]) bad++;
            end
            if (len == 9 * BIT_CYC + 5) par_s = tx2;
            @(posedge clk);
            #1;
            len++;
        end
        check("t6_frame_len", len, FRAME2_CYC);
        check("t6_bits", bad, 0);
        check("t6_bit9", par_s, 1);
        check("t6_idle_tx", tx2, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
